// File: rtl/load_hazard_ctrl.sv
// Load-use hazard and dmem-wait stall controller for the MEM1/MEM2 pipeline.
// Tracks in-flight loads, sequences PC/IF-ID enables, bubbles, freezes and stall stats.
module load_hazard_ctrl #(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_memread,
  input  logic [4:0]       i_id_rd,
  input  logic             i_flush,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_we,
  output logic             o_ifid_we,
  output logic             o_id_bubble,
  output logic             o_freeze,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_timeout
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_ent_t;

  typedef enum logic {RUN, WAIT} st_t;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  sb_ent_t             sb [LOAD_LAT];
  logic [LOAD_LAT-1:0] hit;
  logic                haz, freeze;
  st_t                 state;
  logic [CNT_W-1:0]    wait_cnt, wait_nxt;

  for (genvar k = 0; k < LOAD_LAT; k++) begin : g_hit
    assign hit[k] = sb[k].v && (sb[k].rd != 5'd0) &&
                    ((i_id_use_rs1 && (i_id_rs1 == sb[k].rd)) ||
                     (i_id_use_rs2 && (i_id_rs2 == sb[k].rd)));
  end

  assign haz    = i_id_valid & (|hit);
  assign freeze = i_dmem_req & ~i_dmem_ready;

  // Outputs are forced to their idle values while reset is held, even mid-wait.
  always_comb begin
    o_pc_we     = 1'b1;
    o_ifid_we   = 1'b1;
    o_id_bubble = 1'b0;
    o_freeze    = 1'b0;
    if (i_rst_n) begin
      if (freeze) begin
        o_freeze  = 1'b1;
        o_pc_we   = 1'b0;
        o_ifid_we = 1'b0;
      end else if (i_flush) begin
        o_id_bubble = 1'b1;
      end else if (haz) begin
        o_pc_we     = 1'b0;
        o_ifid_we   = 1'b0;
        o_id_bubble = 1'b1;
      end
    end
  end

  // A bubbled ID slot never enters the scoreboard as a load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LOAD_LAT; k++) sb[k] <= '0;
    end else if (!freeze) begin
      sb[0] <= '{v: i_id_valid & i_id_memread & ~o_id_bubble, rd: i_id_rd};
      for (int k = 1; k < LOAD_LAT; k++) sb[k] <= sb[k-1];
    end
  end

  always_comb begin
    wait_nxt = CNT_W'(1);
    if (state == WAIT)
      wait_nxt = (wait_cnt == TO_LIM) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: if (freeze) begin
          state    <= WAIT;
          wait_cnt <= wait_nxt;
        end
        WAIT: if (freeze) begin
          wait_cnt <= wait_nxt;
        end else begin
          state    <= RUN;
          wait_cnt <= '0;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
      if (freeze && (wait_nxt == TO_LIM)) o_timeout <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_stall_cnt <= '0;
    else if ((freeze || (haz && !i_flush)) && (o_stall_cnt != '1))
      o_stall_cnt <= o_stall_cnt + 1'b1;
  end

endmodule
